lcd_bus_ctrl: RTL and testbench
===============================

Name: lcd_bus_ctrl

Overview:
Parametrised 8080-style parallel LCD bus master supporting both writes and reads. Accepts one command at a time over a valid/ready handshake and drives CS/RS/WR/RD plus a tri-state data bus. Setup, strobe-low and strobe-high timings are programmable independently. Chip select stays low across back-to-back commands. Sits between the TFT pixel/command engine and the panel pins.

Parameters:
DW, 16, data bus width (8 or 16 in use; any value >=1 legal)
CW, 8, width of timing counters and timing inputs

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command; equals (state==IDLE)
cmd_rw  in  1  1=read, 0=write
cmd_rs  in  1  1=data (RS high), 0=register index (RS low)
cmd_wdata  in  DW  write data
t_setup  in  CW  extra setup cycles before strobe
t_low  in  CW  extra strobe-low cycles
t_high  in  CW  extra strobe-high (hold/recovery) cycles
rd_data  out  DW  captured read data
rd_valid  out  1  one-cycle pulse, rd_data valid
busy  out  1  state!=IDLE
lcd_cs_n  out  1  chip select, active-low
lcd_rs  out  1  register/data select
lcd_wr_n  out  1  write strobe, active-low
lcd_rd_n  out  1  read strobe, active-low
lcd_db_o  out  DW  bus output data
lcd_db_oe  out  1  bus output enable (1=drive)
lcd_db_i  in  DW  bus input data

Behaviour:
- Reset values: state IDLE, lcd_cs_n=1, lcd_rs=1, lcd_wr_n=1, lcd_rd_n=1, lcd_db_o=0, lcd_db_oe=0, rd_data=0, rd_valid=0, counter=0. cmd_ready=1 in the first cycle after reset is released.
- Reset mid-operation: aborts the transaction at the next edge. All outputs return to their reset values. No rd_valid is produced.
- States: IDLE, SETUP, STROBE, HOLD. A single down/up counter of width CW is shared by all timed states.
- Accept: a command is accepted on an edge where cmd_valid=1 and state=IDLE (edge k). At accept, cmd_rw, cmd_rs, cmd_wdata, t_setup, t_low and t_high are latched. Input changes after accept have no effect on the current transaction.
- Edge k: state->SETUP, cs_n<=0, lcd_rs<=cmd_rs, counter<=0.
  - Write: db_o<=cmd_wdata and oe<=1.
  - Read: oe<=0 and db_o holds its value.
- SETUP lasts t_setup+1 cycles, then ->STROBE. Write drives wr_n<=0; read drives rd_n<=0.
- STROBE lasts t_low+1 cycles, then ->HOLD with wr_n/rd_n<=1.
  - Read: on that same edge, rd_data<=lcd_db_i (value present in the last STROBE cycle) and rd_valid<=1 for exactly one cycle.
- HOLD lasts t_high+1 cycles, then ->IDLE. oe<=0 on entry to IDLE.
- Total: edge k to IDLE is t_setup+t_low+t_high+3 cycles. Minimum command period is t_setup+t_low+t_high+4 cycles.
- Chip select in IDLE:
  - cmd_valid=1: the command is accepted and cs_n stays 0, with no high glitch.
  - cmd_valid=0: cs_n<=1 at that edge.
- lcd_rs and lcd_db_o hold their values through HOLD and into IDLE until the next accept. wr_n and rd_n are never low simultaneously.
- Timing inputs are unsigned. The maximum value 2^CW-1 gives 2^CW cycles per phase. The counter must not wrap or overflow: compare with equality to the latched value.
- busy=1 in SETUP, STROBE and HOLD; busy=0 in IDLE.

Test Plan:
- Reset: hold rst 3 cycles with random inputs -> all outputs at reset values, cmd_ready=1 after release. Assert rst during STROBE of a read -> next cycle idle values, rd_valid never pulses.
- Single write, DW=16, t=0/0/0, cmd_rs=0, wdata=0x002C:
  - edge k+1: cs_n=0, rs=0, db_o=0x002C, oe=1.
  - wr_n low exactly 1 cycle.
  - cmd_ready returns 3 cycles after accept.
  - cs_n=1 the cycle after, with cmd_valid low.
- Read, t_setup=1, t_low=3, t_high=2, lcd_db_i=0xA5C3 during strobe:
  - rd_n low 4 cycles, oe=0 throughout.
  - rd_valid one-cycle pulse with rd_data=0xA5C3.
  - cycle budget 9.
- Back-to-back writes (0x1111, 0x2222, 0x3333) with cmd_valid held high:
  - cs_n stays 0 across all three.
  - period = 4 cycles at t=0/0/0.
  - three wr_n pulses with correct data.
- Timing inputs changed from 0/0/0 to 5/5/5 immediately after accept -> the current transaction keeps 0/0/0 timing; the next one uses 5/5/5 (strobe low 6 cycles).
- Boundary: t_low=255 with CW=8 -> wr_n low exactly 256 cycles, no counter wrap. DW=8 build -> write of 0xFF is correct on an 8-bit bus.

Source files
------------

// File: rtl/lcd_bus_ctrl_if.sv
// lcd_bus_ctrl_if: command-side handshake between the pixel/command engine and the LCD bus master
interface lcd_bus_ctrl_if #(parameter int DW = 16, parameter int CW = 8);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic          cmd_rs;
  logic [DW-1:0] cmd_wdata;
  logic [CW-1:0] t_setup;
  logic [CW-1:0] t_low;
  logic [CW-1:0] t_high;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  modport master (
    output cmd_valid, cmd_rw, cmd_rs, cmd_wdata, t_setup, t_low, t_high,
    input  cmd_ready, rd_data, rd_valid, busy
  );
  modport slave (
    input  cmd_valid, cmd_rw, cmd_rs, cmd_wdata, t_setup, t_low, t_high,
    output cmd_ready, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: 8080-style parallel LCD bus master with programmable setup/strobe/hold timing
module lcd_bus_ctrl #(
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  lcd_bus_ctrl_if.slave bus,
  output logic          lcd_cs_n,
  output logic          lcd_rs,
  output logic          lcd_wr_n,
  output logic          lcd_rd_n,
  output logic [DW-1:0] lcd_db_o,
  output logic          lcd_db_oe,
  input  logic [DW-1:0] lcd_db_i
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, lim, ts_q, tl_q, th_q;
  logic          rw_q, done, rd_valid_q;
  logic [DW-1:0] rd_data_q;
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  // equality against the latched limit, then clear: a full-scale limit never wraps
  always_comb begin
    lim     = state == SETUP ? ts_q : state == STROBE ? tl_q : th_q;
    done    = cnt == lim;
    state_n = state;
    cnt_n   = cnt + CW'(1);
    if (state == IDLE) begin
      cnt_n   = '0;
      state_n = bus.cmd_valid ? SETUP : IDLE;
    end else if (done) begin
      cnt_n   = '0;
      state_n = state == SETUP ? STROBE : state == STROBE ? HOLD : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ts_q       <= '0;
      tl_q       <= '0;
      th_q       <= '0;
      rw_q       <= 1'b0;
      lcd_cs_n   <= 1'b1;
      lcd_rs     <= 1'b1;
      lcd_wr_n   <= 1'b1;
      lcd_rd_n   <= 1'b1;
      lcd_db_o   <= '0;
      lcd_db_oe  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          lcd_cs_n <= ~bus.cmd_valid;
          if (bus.cmd_valid) begin
            rw_q      <= bus.cmd_rw;
            ts_q      <= bus.t_setup;
            tl_q      <= bus.t_low;
            th_q      <= bus.t_high;
            lcd_rs    <= bus.cmd_rs;
            lcd_db_oe <= ~bus.cmd_rw;
            if (!bus.cmd_rw) lcd_db_o <= bus.cmd_wdata;
          end
        end
        SETUP: if (done) begin
          lcd_wr_n <= rw_q;
          lcd_rd_n <= ~rw_q;
        end
        STROBE: if (done) begin
          lcd_wr_n <= 1'b1;
          lcd_rd_n <= 1'b1;
          if (rw_q) begin
            rd_data_q  <= lcd_db_i;
            rd_valid_q <= 1'b1;
          end
        end
        HOLD: if (done) lcd_db_oe <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb_lcd_bus_ctrl: table-driven, directed and randomized checks against a cycle-offset reference model
module tb_lcd_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_ctrl_if #(.DW(16), .CW(8)) bus ();
  lcd_bus_ctrl_if #(.DW(8), .CW(8))  bus8 ();
  logic        cs_n, rs, wr_n, rd_n, oe;
  logic [15:0] db_o, db_i;
  logic        cs8, rs8, wr8, rd8, oe8;
  logic [7:0]  db8_o;
  logic [7:0]  db8_i = 8'h00;

  lcd_bus_ctrl #(.DW(16), .CW(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .lcd_cs_n(cs_n), .lcd_rs(rs), .lcd_wr_n(wr_n),
    .lcd_rd_n(rd_n), .lcd_db_o(db_o), .lcd_db_oe(oe), .lcd_db_i(db_i)
  );
  lcd_bus_ctrl #(.DW(8), .CW(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .lcd_cs_n(cs8), .lcd_rs(rs8), .lcd_wr_n(wr8),
    .lcd_rd_n(rd8), .lcd_db_o(db8_o), .lcd_db_oe(oe8), .lcd_db_i(db8_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_lo, rd_lo, cs_hi, rdv_cnt;
  bit chk_en = 0;
  bit rnd_dbi = 0;
  logic [15:0] wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a transaction is described by edges elapsed since accept
  bit          m_busy = 0, m_rw = 0;
  int          m_el = 0, m_s = 0, m_l = 0, m_h = 0;
  logic        m_cs = 1, m_rs = 1, m_oe = 0, m_rdv = 0;
  logic [15:0] m_db = 0, m_rdd = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_cs = 1; m_rs = 1; m_db = 0; m_oe = 0; m_rdd = 0; m_rdv = 0; m_el = 0;
    end else begin
      m_rdv = 0;
      if (!m_busy) begin
        m_cs = !bus.cmd_valid;
        if (bus.cmd_valid) begin
          m_busy = 1; m_el = 0; m_rw = bus.cmd_rw; m_rs = bus.cmd_rs; m_oe = !bus.cmd_rw;
          m_s = int'(bus.t_setup); m_l = int'(bus.t_low); m_h = int'(bus.t_high);
          if (!bus.cmd_rw) m_db = bus.cmd_wdata;
        end
      end else begin
        m_el++;
        if (m_rw && m_el == m_s + m_l + 2) begin m_rdd = db_i; m_rdv = 1; end
        if (m_el == m_s + m_l + m_h + 3) begin m_busy = 0; m_oe = 0; end
      end
    end
  end

  function automatic logic strobe_n(input bit rd);
    return !(m_busy && m_rw == rd && m_el >= m_s + 1 && m_el <= m_s + m_l + 1);
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("cmd_ready", bus.cmd_ready, !m_busy);
    chk("busy", bus.busy, m_busy);
    chk("cs_n", cs_n, m_cs);
    chk("rs", rs, m_rs);
    chk("wr_n", wr_n, strobe_n(0));
    chk("rd_n", rd_n, strobe_n(1));
    chk("db_o", db_o, m_db);
    chk("db_oe", oe, m_oe);
    chk("rd_data", bus.rd_data, m_rdd);
    chk("rd_valid", bus.rd_valid, m_rdv);
    if (!wr_n) begin wr_lo++; wq.push_back(db_o); end
    if (!rd_n) rd_lo++;
    if (cs_n) cs_hi++;
    if (bus.rd_valid) rdv_cnt++;
  end

  always begin
    @(posedge clk); #1;
    if (rnd_dbi) db_i = 16'($urandom);
  end

  task automatic issue(input bit rw, input bit rsel, input logic [15:0] wd,
                       input int s, input int l, input int h, input bit hold);
    int n = 0;
    while (!bus.cmd_ready && n < 2000) begin @(posedge clk); #1; n++; end
    if (!bus.cmd_ready) chk("ready_timeout", 0, 1);
    bus.cmd_rw = rw; bus.cmd_rs = rsel; bus.cmd_wdata = wd;
    bus.t_setup = 8'(s); bus.t_low = 8'(l); bus.t_high = 8'(h); bus.cmd_valid = 1;
    @(posedge clk); #1;
    bus.cmd_valid = hold; wr_lo = 0; rd_lo = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!bus.cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
  endtask

  typedef struct {
    bit rw; bit rsel; logic [15:0] wd; int s; int l; int h; logic [15:0] dbi;
    int e_wlo; int e_rlo; int e_lat; logic [15:0] e_rd;
  } vec_t;
  vec_t tv[5];
  logic [15:0] bb[3];
  int t_acc[3];

  initial begin
    int n;
    tv[0] = '{0, 0, 16'h002C, 0, 0, 0, 16'h0000, 1, 0, 3, 16'h0000};
    tv[1] = '{1, 1, 16'h0000, 1, 3, 2, 16'hA5C3, 0, 4, 9, 16'hA5C3};
    tv[2] = '{0, 1, 16'hBEEF, 2, 1, 0, 16'h0000, 2, 0, 6, 16'h0000};
    tv[3] = '{0, 1, 16'h5A5A, 0, 255, 0, 16'h0000, 256, 0, 258, 16'h0000};
    tv[4] = '{1, 0, 16'h0000, 0, 0, 0, 16'h1234, 0, 1, 3, 16'h1234};
    bb[0] = 16'h1111; bb[1] = 16'h2222; bb[2] = 16'h3333;
    bus.cmd_valid = 0; bus.cmd_rw = 0; bus.cmd_rs = 0; bus.cmd_wdata = 0;
    bus.t_setup = 0; bus.t_low = 0; bus.t_high = 0; db_i = 0;
    bus8.cmd_valid = 0; bus8.cmd_rw = 0; bus8.cmd_rs = 0; bus8.cmd_wdata = 0;
    bus8.t_setup = 0; bus8.t_low = 0; bus8.t_high = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk_en = 1;
      bus.cmd_valid = 1'($urandom); bus.cmd_rw = 1'($urandom); bus.cmd_rs = 1'($urandom);
      bus.cmd_wdata = 16'($urandom); db_i = 16'($urandom);
    end
    rst = 0; bus.cmd_valid = 0;
    chk("ready_after_rst", bus.cmd_ready, 1);
    chk("cs_after_rst", cs_n, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      db_i = tv[i].dbi;
      issue(tv[i].rw, tv[i].rsel, tv[i].wd, tv[i].s, tv[i].l, tv[i].h, 0);
      wait_idle(n);
      chk("vec_wr_low", wr_lo, tv[i].e_wlo);
      chk("vec_rd_low", rd_lo, tv[i].e_rlo);
      chk("vec_latency", n, tv[i].e_lat);
      if (tv[i].rw) chk("vec_rd_data", bus.rd_data, tv[i].e_rd);
      @(posedge clk); #1;
      chk("vec_cs_release", cs_n, 1);
    end

    wq.delete();
    for (int i = 0; i < 3; i++) begin
      n = 0;
      bus.cmd_wdata = bb[i]; bus.cmd_rw = 0; bus.cmd_rs = 1; bus.cmd_valid = 1;
      bus.t_setup = 0; bus.t_low = 0; bus.t_high = 0;
      while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
      t_acc[i] = cyc;
      @(posedge clk); #1;
      if (i == 0) cs_hi = 0;
    end
    bus.cmd_valid = 0;
    wait_idle(n);
    chk("b2b_cs_high", cs_hi, 0);
    chk("b2b_period0", t_acc[1] - t_acc[0], 4);
    chk("b2b_period1", t_acc[2] - t_acc[1], 4);
    chk("b2b_pulses", wq.size(), 3);
    for (int i = 0; i < 3 && i < wq.size(); i++) chk("b2b_data", wq[i], bb[i]);

    issue(0, 1, 16'hCAFE, 0, 0, 0, 0);
    bus.t_setup = 5; bus.t_low = 5; bus.t_high = 5; bus.cmd_wdata = 16'hDEAD;
    wait_idle(n);
    chk("tchg_cur_low", wr_lo, 1);
    chk("tchg_cur_lat", n, 3);
    issue(0, 1, 16'h0F0F, 5, 5, 5, 0);
    wait_idle(n);
    chk("tchg_next_low", wr_lo, 6);
    chk("tchg_next_lat", n, 18);

    db_i = 16'h7E57;
    issue(1, 1, 16'h0000, 1, 3, 2, 0);
    rdv_cnt = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_in_strobe", rd_n, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_rd_n", rd_n, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cs", cs_n, 1);
    chk("abort_oe", oe, 0);
    repeat (8) begin @(posedge clk); #1; end
    chk("abort_no_rdv", rdv_cnt, 0);

    bus8.cmd_wdata = 8'hFF; bus8.cmd_rs = 1; bus8.cmd_valid = 1;
    @(posedge clk); #1;
    bus8.cmd_valid = 0;
    chk("dw8_db", db8_o, 8'hFF);
    chk("dw8_oe", oe8, 1);
    chk("dw8_cs", cs8, 0);
    @(posedge clk); #1;
    chk("dw8_wr_low", wr8, 0);
    @(posedge clk); #1;
    chk("dw8_wr_high", wr8, 1);
    @(posedge clk); #1;
    chk("dw8_ready", bus8.cmd_ready, 1);

    rnd_dbi = 1;
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 2) == 0));
      bus.cmd_wdata = 16'($urandom); bus.cmd_rw = 1'($urandom); bus.cmd_rs = 1'($urandom);
      bus.t_setup = 8'($urandom); bus.t_low = 8'($urandom); bus.t_high = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    bus.cmd_valid = 0;
    wait_idle(n);
    chk("final_idle", bus.cmd_ready, 1);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
